// File: rtl/test_run_ctrl.sv
// test_run_ctrl: reset and checkpoint sequencer for self-checking rv32i ISA runs.
//
// The core is held in reset after i_start and then released. The sequencer then
// follows the committed PC stream against a loadable table of checkpoint PCs.
// Each checkpoint hit at index k>0 grades test k-1 from the LEDR pass flag. A
// watchdog bounds the number of RUN cycles between consecutive hits.
//
// Ports:
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_start            one-cycle start/restart pulse (honoured in IDLE/DONE/TIMEOUT)
//   i_cfg_we/idx/pc    checkpoint table write port (honoured in IDLE/DONE/TIMEOUT)
//   i_pc_debug         committed PC from the core
//   i_insn_vld         commit valid from the core
//   i_io_ledr          core LEDR output; PASS_VAL means the preceding test passed
//   o_dut_rst_n        active-low reset to the core
//   o_busy             high in HOLD or RUN
//   o_done/o_timeout   sticky completion / watchdog flags
//   o_test_idx         next expected checkpoint index
//   o_pass_cnt/o_fail_cnt, o_result_map, o_all_pass   grading results
module test_run_ctrl #(
  parameter int unsigned NUM_CKPT    = 40,
  parameter int unsigned IDXW        = $clog2(NUM_CKPT),
  parameter int unsigned RST_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [31:0] PASS_VAL    = 32'h1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_cfg_we,
  input  logic [IDXW-1:0]     i_cfg_idx,
  input  logic [31:0]         i_cfg_pc,
  input  logic [31:0]         i_pc_debug,
  input  logic                i_insn_vld,
  input  logic [31:0]         i_io_ledr,
  output logic                o_dut_rst_n,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_timeout,
  output logic [IDXW-1:0]     o_test_idx,
  output logic [IDXW:0]       o_pass_cnt,
  output logic [IDXW:0]       o_fail_cnt,
  output logic [NUM_CKPT-2:0] o_result_map,
  output logic                o_all_pass
);

  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned HCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_CKPT - 1);
  localparam logic [IDXW:0]   CNT_ONE  = (IDXW + 1)'(1);
  localparam logic [WDW-1:0]  WD_ONE   = WDW'(1);
  localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT_CYC);
  localparam logic [HCW-1:0]  HC_ONE   = HCW'(1);
  localparam logic [HCW-1:0]  HC_LAST  = HCW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StRun,
    StDone,
    StTimeout
  } state_e;

  state_e         state;
  logic [HCW-1:0] hold_cnt;
  logic [WDW-1:0] wdog;
  logic [31:0]    ckpt_pc [NUM_CKPT];

  logic          cfg_open;
  logic          hit;
  logic          grade;
  logic          led_pass;
  logic [IDXW:0] fail_cnt_nx;

  // The table is only writable while the core is not running.
  assign cfg_open = (state == StIdle) || (state == StDone) || (state == StTimeout);

  always_comb begin
    hit         = 1'b0;
    grade       = 1'b0;
    led_pass    = 1'b0;
    fail_cnt_nx = o_fail_cnt;
    if (state == StRun) begin
      hit = i_insn_vld && (i_pc_debug == ckpt_pc[o_test_idx]);
    end
    grade    = hit && (o_test_idx != '0);
    led_pass = (i_io_ledr == PASS_VAL);
    if (grade && !led_pass) begin
      fail_cnt_nx = o_fail_cnt + CNT_ONE;
    end
  end

  // Table storage has no reset; it is loaded before each start.
  always_ff @(posedge i_clk) begin
    if (i_cfg_we && cfg_open && (int'(i_cfg_idx) < NUM_CKPT)) begin
      ckpt_pc[i_cfg_idx] <= i_cfg_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= StIdle;
      hold_cnt     <= '0;
      wdog         <= '0;
      o_dut_rst_n  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_timeout    <= 1'b0;
      o_test_idx   <= '0;
      o_pass_cnt   <= '0;
      o_fail_cnt   <= '0;
      o_result_map <= '0;
      o_all_pass   <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone, StTimeout: begin
          if (i_start) begin
            state        <= StHold;
            hold_cnt     <= '0;
            wdog         <= '0;
            o_dut_rst_n  <= 1'b0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_timeout    <= 1'b0;
            o_test_idx   <= '0;
            o_pass_cnt   <= '0;
            o_fail_cnt   <= '0;
            o_result_map <= '0;
            o_all_pass   <= 1'b0;
          end
        end
        StHold: begin
          if (hold_cnt == HC_LAST) begin
            state       <= StRun;
            o_dut_rst_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HC_ONE;
          end
        end
        StRun: begin
          if (hit) begin
            wdog <= '0;
            if (grade) begin
              if (led_pass) begin
                o_pass_cnt                         <= o_pass_cnt + CNT_ONE;
                o_result_map[o_test_idx - IDX_ONE] <= 1'b1;
              end
              o_fail_cnt <= fail_cnt_nx;
            end
            if (o_test_idx == IDX_LAST) begin
              // Index stays on the final entry: NUM_CKPT may not fit in IDXW bits.
              state       <= StDone;
              o_dut_rst_n <= 1'b0;
              o_busy      <= 1'b0;
              o_done      <= 1'b1;
              o_all_pass  <= (fail_cnt_nx == '0);
            end else begin
              o_test_idx <= o_test_idx + IDX_ONE;
            end
          end else if (wdog == WD_LIMIT) begin
            state       <= StTimeout;
            o_dut_rst_n <= 1'b0;
            o_busy      <= 1'b0;
            o_timeout   <= 1'b1;
          end else begin
            wdog <= wdog + WD_ONE;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
